// File: rtl/mmio_csr_bank_mc_pkg.sv
// Shared types for the multi-channel MMIO CSR bank: opcodes, tags,
// register indices, channel register struct and address decoder.
package mmio_csr_pkg;

  localparam logic [7:0] OP_READ  = 8'h00;
  localparam logic [7:0] OP_WRITE = 8'h01;

  localparam logic [7:0] RSP_TAG_OK  = 8'd2;
  localparam logic [7:0] RSP_TAG_ERR = 8'd3;

  // Register index within a window; byte offset = index * 8.
  localparam logic [2:0] REG_CMD    = 3'd0;
  localparam logic [2:0] REG_SRC    = 3'd1;
  localparam logic [2:0] REG_DST    = 3'd2;
  localparam logic [2:0] REG_LEN    = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;
  localparam logic [2:0] REG_START  = 3'd5;
  localparam logic [2:0] REG_CYCLES = 3'd6;
  localparam logic [2:0] REG_TX_LEN = 3'd7;

  typedef struct packed {
    logic [63:0] cmd;
    logic [63:0] src;
    logic [63:0] dst;
    logic [63:0] len;
    logic [63:0] status;
    logic [63:0] start_comp;
    logic [63:0] cycles;
    logic [63:0] tx_len;
  } ch_regs_t;

  typedef struct packed {
    logic       ok;
    logic [2:0] ch;
    logic [2:0] idx;
  } dec_t;

  // sl = log2 of the channel stride
  function automatic dec_t addr_decode(
    input logic [63:0] addr,
    input int unsigned num_ch,
    input int unsigned sl
  );
    dec_t        d;
    logic [63:0] ch64;
    logic [63:0] off;
    ch64  = addr >> sl;
    off   = addr & ((64'd1 << sl) - 64'd1);
    d.ch  = ch64[2:0];
    d.idx = off[5:3];
    d.ok  = (ch64 < 64'(num_ch)) && (off < 64'h40)
            && (off[2:0] == 3'd0);
    return d;
  endfunction

  function automatic logic [63:0] reg_rd(
    input ch_regs_t   r,
    input logic [2:0] idx
  );
    case (idx)
      REG_CMD:    return r.cmd;
      REG_SRC:    return r.src;
      REG_DST:    return r.dst;
      REG_LEN:    return r.len;
      REG_STATUS: return r.status;
      REG_START:  return r.start_comp;
      REG_CYCLES: return r.cycles;
      default:    return r.tx_len;
    endcase
  endfunction

endpackage

// File: rtl/mmio_csr_bank_mc_if.sv
// Host-side bus: request stream (op/address/data, valid/ready) and
// read response stream (read_data/valid/ready).
interface mmio_csr_bank_mc_if;
  logic [7:0]  op_code;
  logic [63:0] address;
  logic [63:0] payload_data;
  logic        payload_valid;
  logic        payload_ready;
  logic [71:0] read_data;
  logic        read_data_valid;
  logic        read_data_ready;

  modport master (
    output op_code, address, payload_data, payload_valid,
    output read_data_ready,
    input  payload_ready, read_data, read_data_valid
  );

  modport slave (
    input  op_code, address, payload_data, payload_valid,
    input  read_data_ready,
    output payload_ready, read_data, read_data_valid
  );
endinterface

// File: rtl/mmio_csr_bank_mc_rsp_fifo.sv
// Response FIFO with registered output stage. Ports: clk/rst_n, push/wdata,
// hold (blocks loading the output stage), out_ready, count, out_data/valid.
module mmio_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 72
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   hold,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic [W-1:0]           out_data,
  output logic                   out_valid
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rp;
  logic [AW-1:0] wp;
  logic          pop;

  assign pop = (!out_valid || out_ready) && !hold && (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rp        <= '0;
      wp        <= '0;
      count     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) begin
        out_data  <= mem[rp];
        out_valid <= 1'b1;
        rp        <= rp + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/mmio_csr_bank_mc.sv
// NUM_CH-window CSR bank for DMA/compute engines with buffered read replies.
// Ports: aclk/aresetn, bus (slave), dma_* / comp_* per-channel I/O.
// Optional MMIO_ERR_RESP_EN: error replies (tag 3) for invalid accesses.
module mmio_csr_bank_mc
  import mmio_csr_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int RSP_DEPTH = 4,
  parameter int CH_STRIDE = 64
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  mmio_csr_bank_mc_if.slave    bus,
  input  logic                 dma_output_active,
  output logic [NUM_CH-1:0]    dma_start,
  output logic [NUM_CH-1:0]    dma_direction,
  output logic [64*NUM_CH-1:0] dma_src_addr,
  output logic [64*NUM_CH-1:0] dma_dst_addr,
  output logic [64*NUM_CH-1:0] dma_len,
  output logic [NUM_CH-1:0]    comp_start,
  output logic [64*NUM_CH-1:0] comp_cycles,
  input  logic [NUM_CH-1:0]    dma_status,
  input  logic [NUM_CH-1:0]    dma_status_valid,
  input  logic [NUM_CH-1:0]    computation_status,
  input  logic [NUM_CH-1:0]    computation_status_valid,
  input  logic [NUM_CH-1:0]    clear_dma_start,
  input  logic [64*NUM_CH-1:0] dma_tx_len,
  input  logic [NUM_CH-1:0]    dma_tx_len_valid
);
  localparam int SL = $clog2(CH_STRIDE);
  localparam int CW = $clog2(RSP_DEPTH) + 1;

  ch_regs_t    regs [NUM_CH];
  dec_t        dec;
  logic        acc;
  logic        is_rd;
  logic        is_wr;
  logic        push;
  logic [71:0] push_data;
  logic [63:0] rd_val;
  logic [CW-1:0] cnt;

  assign dec = addr_decode(bus.address, NUM_CH, SL);
  assign bus.payload_ready = cnt < CW'(RSP_DEPTH);
  assign acc   = bus.payload_valid && bus.payload_ready;
  assign is_rd = acc && (bus.op_code == OP_READ);
  assign is_wr = acc && (bus.op_code == OP_WRITE);

  always_comb begin
    rd_val = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (dec.ch == 3'(c)) rd_val = reg_rd(regs[c], dec.idx);
  end

`ifdef MMIO_ERR_RESP_EN
  assign push = is_rd || (is_wr && !dec.ok);
  assign push_data =
    dec.ok ? {rd_val, RSP_TAG_OK} :
    is_rd  ? {64'hDEAD_DEAD_DEAD_DEAD, RSP_TAG_ERR} :
             {64'd0, RSP_TAG_ERR};
`else
  assign push = is_rd;
  assign push_data = {dec.ok ? rd_val : 64'd0, RSP_TAG_OK};
`endif

  // Later assignments win: host write beats clear, hw strobe beats W1C.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int c = 0; c < NUM_CH; c++) regs[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (clear_dma_start[c]) regs[c].cmd <= '0;
        if (is_wr && dec.ok && dec.ch == 3'(c)) begin
          unique case (1'b1)
            dec.idx == REG_CMD:    regs[c].cmd <= bus.payload_data;
            dec.idx == REG_SRC:    regs[c].src <= bus.payload_data;
            dec.idx == REG_DST:    regs[c].dst <= bus.payload_data;
            dec.idx == REG_LEN:    regs[c].len <= bus.payload_data;
            dec.idx == REG_STATUS:
              regs[c].status <= {62'd0,
                regs[c].status[1:0] & ~bus.payload_data[1:0]};
            dec.idx == REG_START:  regs[c].start_comp <= bus.payload_data;
            dec.idx == REG_CYCLES: regs[c].cycles <= bus.payload_data;
            dec.idx == REG_TX_LEN: ;
          endcase
        end
        if (dma_status_valid[c])
          regs[c].status[0] <= dma_status[c];
        if (computation_status_valid[c])
          regs[c].status[1] <= computation_status[c];
        if (dma_tx_len_valid[c])
          regs[c].tx_len <= dma_tx_len[64*c +: 64];
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_out
    assign dma_start[c]           = regs[c].cmd[0];
    assign dma_direction[c]       = regs[c].cmd[1];
    assign dma_src_addr[64*c+:64] = regs[c].src;
    assign dma_dst_addr[64*c+:64] = regs[c].dst;
    assign dma_len[64*c+:64]      = regs[c].len;
    assign comp_start[c]          = regs[c].start_comp[0];
    assign comp_cycles[64*c+:64]  = regs[c].cycles;
  end

  mmio_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .W     (72)
  ) u_rsp (
    .clk       (aclk),
    .rst_n     (aresetn),
    .push      (push),
    .wdata     (push_data),
    .hold      (dma_output_active),
    .out_ready (bus.read_data_ready),
    .count     (cnt),
    .out_data  (bus.read_data),
    .out_valid (bus.read_data_valid)
  );
endmodule

// File: tb/tb_mmio_csr_bank_mc.sv
// Randomized + directed bench for mmio_csr_bank_mc against a
// register-array / response-queue reference model.
module tb_mmio_csr_bank_mc;
  localparam int NC = 2;
  localparam int DEPTH = 4;
  localparam int STRIDE = 64;

  logic aclk = 0;
  logic aresetn = 0;
  logic dma_output_active = 0;
  logic [NC-1:0] dma_start, dma_direction, comp_start;
  logic [64*NC-1:0] dma_src_addr, dma_dst_addr, dma_len, comp_cycles;
  logic [NC-1:0] dma_status = 0, dma_status_valid = 0;
  logic [NC-1:0] computation_status = 0, computation_status_valid = 0;
  logic [NC-1:0] clear_dma_start = 0, dma_tx_len_valid = 0;
  logic [64*NC-1:0] dma_tx_len = 0;

  mmio_csr_bank_mc_if bus();

  mmio_csr_bank_mc #(
    .NUM_CH(NC), .RSP_DEPTH(DEPTH), .CH_STRIDE(STRIDE)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .bus(bus),
    .dma_output_active(dma_output_active),
    .dma_start(dma_start), .dma_direction(dma_direction),
    .dma_src_addr(dma_src_addr), .dma_dst_addr(dma_dst_addr),
    .dma_len(dma_len), .comp_start(comp_start),
    .comp_cycles(comp_cycles), .dma_status(dma_status),
    .dma_status_valid(dma_status_valid),
    .computation_status(computation_status),
    .computation_status_valid(computation_status_valid),
    .clear_dma_start(clear_dma_start), .dma_tx_len(dma_tx_len),
    .dma_tx_len_valid(dma_tx_len_valid)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [71:0] act,
                     input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
               $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m [NC][8];
  logic [71:0] mq[$];
  logic        mov = 0;
  logic [71:0] mod = 0;
  logic [71:0] rsp_log[$];

  always @(posedge aclk) begin
    logic [63:0] a, off, d;
    logic [71:0] e;
    int ch, r;
    bit ok, acc, ld, rd, wr;
    if (!aresetn) begin
      for (int c = 0; c < NC; c++)
        for (int k = 0; k < 8; k++) m[c][k] = 0;
      mq.delete();
      mov = 0;
      mod = 0;
    end else begin
      a   = bus.address;
      d   = bus.payload_data;
      off = a % STRIDE;
      ok  = (a / STRIDE < NC) && (off < 64) && (off % 8 == 0);
      ch  = ok ? int'(a / STRIDE) : 0;
      r   = int'(off / 8);
      acc = bus.payload_valid && (mq.size() < DEPTH);
      rd  = acc && bus.op_code == 8'h00;
      wr  = acc && bus.op_code == 8'h01;
      ld  = (!mov || bus.read_data_ready) && !dma_output_active
            && mq.size() > 0;
      if (ld) begin
        mod = mq.pop_front();
        mov = 1;
      end else if (bus.read_data_ready) begin
        mov = 0;
      end
`ifdef MMIO_ERR_RESP_EN
      e = ok ? {m[ch][r], 8'h02} : {64'hDEADDEADDEADDEAD, 8'h03};
      if (rd) mq.push_back(e);
      if (wr && !ok) mq.push_back({64'd0, 8'h03});
`else
      e = ok ? {m[ch][r], 8'h02} : {64'd0, 8'h02};
      if (rd) mq.push_back(e);
`endif
      for (int c = 0; c < NC; c++)
        if (clear_dma_start[c]) m[c][0] = 0;
      if (wr && ok) begin
        if (r == 4) m[ch][4] = m[ch][4] & ~(d & 64'd3);
        else if (r != 7) m[ch][r] = d;
      end
      for (int c = 0; c < NC; c++) begin
        if (dma_status_valid[c]) m[c][4][0] = dma_status[c];
        if (computation_status_valid[c])
          m[c][4][1] = computation_status[c];
        if (dma_tx_len_valid[c]) m[c][7] = dma_tx_len[64*c +: 64];
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge aclk) begin
    if (aresetn) begin
      chk("payload_ready", bus.payload_ready, mq.size() < DEPTH);
      chk("read_data_valid", bus.read_data_valid, mov);
      if (mov) chk("read_data", bus.read_data, mod);
      for (int c = 0; c < NC; c++) begin
        chk("dma_start", dma_start[c], m[c][0][0]);
        chk("dma_direction", dma_direction[c], m[c][0][1]);
        chk("dma_src_addr", dma_src_addr[64*c +: 64], m[c][1]);
        chk("dma_dst_addr", dma_dst_addr[64*c +: 64], m[c][2]);
        chk("dma_len", dma_len[64*c +: 64], m[c][3]);
        chk("comp_start", comp_start[c], m[c][5][0]);
        chk("comp_cycles", comp_cycles[64*c +: 64], m[c][6]);
      end
      if (bus.read_data_valid && bus.read_data_ready)
        rsp_log.push_back(bus.read_data);
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic send(input logic [7:0] op, input logic [63:0] a,
                      input logic [63:0] d);
    bit acc = 0;
    bus.op_code = op;
    bus.address = a;
    bus.payload_data = d;
    bus.payload_valid = 1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge aclk);
      acc = bus.payload_ready;
      tick();
    end
    if (!acc) chk("send_timeout", 0, 1);
    bus.payload_valid = 0;
  endtask

  // read, then sample the response two cycles later
  task automatic rd_chk(input string name, input logic [63:0] a,
                        input logic [71:0] exp);
    send(8'h00, a, 0);
    @(negedge aclk);
    @(negedge aclk);
    chk({name, "_valid"}, bus.read_data_valid, 1);
    chk(name, bus.read_data, exp);
  endtask

  initial begin
    logic [63:0] a;
    int sel;
    bus.op_code = 0;
    bus.address = 0;
    bus.payload_data = 0;
    bus.payload_valid = 0;
    bus.read_data_ready = 1;
    repeat (3) tick();
    aresetn = 1;
    @(negedge aclk);
    chk("rst_ready", bus.payload_ready, 1);
    chk("rst_valid", bus.read_data_valid, 0);
    chk("rst_rdata", bus.read_data, 0);
    chk("rst_src", dma_src_addr, 0);
    tick();

    // write ch1 SRC then read it: valid exactly two cycles later
    send(8'h01, 64'h48, 64'h1000);
    send(8'h00, 64'h48, 0);
    @(negedge aclk);
    chk("lat_early", bus.read_data_valid, 0);
    @(negedge aclk);
    chk("lat_valid", bus.read_data_valid, 1);
    chk("ch1_src_rd", bus.read_data, {64'h1000, 8'h02});
    chk("ch1_src_out", dma_src_addr[127:64], 64'h1000);
    chk("ch0_src_out", dma_src_addr[63:0], 0);
    tick();

    // backpressure: 5 reads fit (stage + 4), then ready drops
    send(8'h01, 64'h10, 64'h2000);
    send(8'h01, 64'h18, 64'h30);
    send(8'h01, 64'h30, 64'h77);
    send(8'h01, 64'h28, 64'h1);
    tick();
    rsp_log.delete();
    bus.read_data_ready = 0;
    send(8'h00, 64'h10, 0);
    send(8'h00, 64'h18, 0);
    send(8'h00, 64'h30, 0);
    send(8'h00, 64'h28, 0);
    send(8'h00, 64'h48, 0);
    @(negedge aclk);
    chk("bp_ready_low", bus.payload_ready, 0);
    tick();
    bus.read_data_ready = 1;
    send(8'h00, 64'h08, 0);
    repeat (12) tick();
    chk("bp_count", rsp_log.size(), 6);
    if (rsp_log.size() == 6) begin
      chk("bp_r0", rsp_log[0], {64'h2000, 8'h02});
      chk("bp_r1", rsp_log[1], {64'h30, 8'h02});
      chk("bp_r2", rsp_log[2], {64'h77, 8'h02});
      chk("bp_r3", rsp_log[3], {64'h1, 8'h02});
      chk("bp_r4", rsp_log[4], {64'h1000, 8'h02});
      chk("bp_r5", rsp_log[5], {64'h0, 8'h02});
    end

    // dma_output_active holds off the output stage
    dma_output_active = 1;
    send(8'h00, 64'h10, 0);
    send(8'h00, 64'h18, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      chk("act_hold", bus.read_data_valid, 0);
    end
    tick();
    dma_output_active = 0;
    tick();
    @(negedge aclk);
    chk("act_release", bus.read_data_valid, 1);
    chk("act_data", bus.read_data, {64'h2000, 8'h02});
    repeat (4) tick();

    // STATUS: hw strobe beats same-cycle W1C; W1C alone clears
    dma_status = 2'b01;
    dma_status_valid = 2'b01;
    send(8'h01, 64'h20, 64'h1);
    dma_status_valid = 0;
    rd_chk("status_set", 64'h20, {64'h1, 8'h02});
    tick();
    send(8'h01, 64'h20, 64'h1);
    rd_chk("status_clr", 64'h20, {64'h0, 8'h02});
    tick();

    // CMD: host write beats same-cycle clear; clear alone zeroes
    clear_dma_start = 2'b01;
    send(8'h01, 64'h00, 64'h3);
    clear_dma_start = 0;
    @(negedge aclk);
    chk("cmd_start", dma_start[0], 1);
    chk("cmd_dir", dma_direction[0], 1);
    tick();
    clear_dma_start = 2'b01;
    tick();
    clear_dma_start = 0;
    @(negedge aclk);
    chk("cmd_cleared", {dma_direction[0], dma_start[0]}, 0);
    tick();

    // TX_LEN is hardware-only
    dma_tx_len = {64'h555, 64'h0};
    dma_tx_len_valid = 2'b10;
    tick();
    dma_tx_len_valid = 0;
    send(8'h01, 64'h78, 64'hFFFF);
    rd_chk("tx_len", 64'h78, {64'h555, 8'h02});
    tick();

    // invalid channel
`ifdef MMIO_ERR_RESP_EN
    rd_chk("bad_addr", 64'h88, {64'hDEADDEADDEADDEAD, 8'h03});
`else
    rd_chk("bad_addr", 64'h88, {64'h0, 8'h02});
`endif
    tick();

    // reset with responses pending flushes them
    bus.read_data_ready = 0;
    send(8'h00, 64'h10, 0);
    send(8'h00, 64'h18, 0);
    send(8'h00, 64'h08, 0);
    aresetn = 0;
    tick();
    aresetn = 1;
    bus.read_data_ready = 1;
    @(negedge aclk);
    chk("flush_valid", bus.read_data_valid, 0);
    chk("flush_ready", bus.payload_ready, 1);
    tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0) a = {$urandom, $urandom};
      else if (sel == 1)
        a = 64'($urandom_range(0, 3) * 64 + $urandom_range(0, 7) * 8
                + $urandom_range(1, 7));
      else
        a = 64'($urandom_range(0, 2) * 64 + $urandom_range(0, 7) * 8);
      sel = int'($urandom_range(0, 19));
      bus.op_code = sel < 9 ? 8'h00 : sel < 18 ? 8'h01 : 8'($urandom);
      bus.address = a;
      bus.payload_data = {$urandom, $urandom};
      bus.payload_valid = $urandom_range(0, 3) != 0;
      bus.read_data_ready = $urandom_range(0, 2) != 0;
      dma_output_active = $urandom_range(0, 5) == 0;
      dma_status = 2'($urandom);
      dma_status_valid = 2'($urandom & $urandom & $urandom);
      computation_status = 2'($urandom);
      computation_status_valid = 2'($urandom & $urandom & $urandom);
      clear_dma_start = 2'($urandom & $urandom & $urandom);
      dma_tx_len = {$urandom, $urandom, $urandom, $urandom};
      dma_tx_len_valid = 2'($urandom & $urandom & $urandom);
      aresetn = $urandom_range(0, 499) != 0;
      tick();
    end
    aresetn = 1;
    bus.payload_valid = 0;
    bus.read_data_ready = 1;
    dma_output_active = 0;
    dma_status_valid = 0;
    computation_status_valid = 0;
    clear_dma_start = 0;
    dma_tx_len_valid = 0;
    repeat (20) tick();
    @(negedge aclk);
    chk("drained", bus.read_data_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mmio_csr_bank_mc.md
Name: mmio_csr_bank_mc

Overview:
Multi-channel successor to the single-channel DMA/compute CSR bank. It decodes the host payload stream (op_code, address, data) into NUM_CH identical 8-register channel windows. Each window drives one DMA engine and one compute unit. Read responses are buffered in a RSP_DEPTH-entry FIFO with real backpressure on payload_ready, replacing the single pending slot. Sits between the network payload parser and the per-channel DMA/compute engines.

Parameters:
NUM_CH, 2, number of channel register windows (1..8)
RSP_DEPTH, 4, read-response FIFO entries (power of 2, >=2)
CH_STRIDE, 64, byte stride between channel windows (power of 2, >=64)

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
op_code  in  8  0x00 read, 0x01 write, others ignored (accepted, no effect)
address  in  64  byte address = ch*CH_STRIDE + reg*8
payload_data  in  64  write data
payload_valid  in  1  request valid
payload_ready  out  1  request accepted when valid&ready
read_data  out  72  {data[63:0], tag[7:0]}
read_data_valid  out  1  response valid
read_data_ready  in  1  response accept
dma_output_active  in  1  blocks loading of a new response into the output stage
dma_start  out  NUM_CH  per-channel CMD[0]
dma_direction  out  NUM_CH  per-channel CMD[1]; 0 = H2D, 1 = D2H
dma_src_addr  out  64*NUM_CH  SRC register, channel c at [64c+:64]
dma_dst_addr  out  64*NUM_CH  DST register
dma_len  out  64*NUM_CH  LEN register
comp_start  out  NUM_CH  per-channel START_COMP[0]
comp_cycles  out  64*NUM_CH  CYCLES register
dma_status  in  NUM_CH  DMA done
dma_status_valid  in  NUM_CH  per-channel strobe
computation_status  in  NUM_CH  compute done
computation_status_valid  in  NUM_CH  per-channel strobe
clear_dma_start  in  NUM_CH  per-channel CMD clear
dma_tx_len  in  64*NUM_CH  transferred length
dma_tx_len_valid  in  NUM_CH  per-channel strobe

Behaviour:
- Register offsets within a window: 0x00 CMD, 0x08 SRC, 0x10 DST, 0x18 LEN, 0x20 STATUS, 0x28 START_COMP, 0x30 CYCLES, 0x38 TX_LEN (read-only).
- Channel index = address / CH_STRIDE. Window offset = address mod CH_STRIDE.
- Invalid address: channel >= NUM_CH, offset >= 0x40, or offset not 8-aligned. Writes to an invalid address are dropped. Reads of an invalid address return data 0, tag 8'd2.
- Reset: all registers 0; read_data 0; read_data_valid 0; FIFO empty; payload_ready 1 on the first cycle after reset.
- payload_ready = (FIFO count < RSP_DEPTH). It applies to every op_code, so requests are never reordered.
- Read accepted in cycle T: {reg, 8'd2} is sampled in T and pushed at edge T+1.
- Output stage: loads the FIFO head when (!read_data_valid || read_data_ready) && !dma_output_active && FIFO non-empty.
- Minimum read-to-valid latency is 2 cycles.
- Once read_data_valid is asserted, it and read_data hold until read_data_ready. dma_output_active never drops a valid.
- Push and pop in the same cycle: count is unchanged. This is allowed when full, but payload_ready still reflects count before the pop.
- STATUS bit0 := dma_status on its strobe; bit1 := computation_status on its strobe.
- Host writes to STATUS are write-1-to-clear on bits[1:0]. A hardware strobe in the same cycle wins.
- TX_LEN updates on dma_tx_len_valid. Host writes to TX_LEN are ignored.
- clear_dma_start[c] zeroes CMD of channel c. A host write to the same CMD in the same cycle wins.
- A read of a register being updated in the same cycle returns the pre-update value.
- Reset mid-transfer: FIFO and output stage are flushed; pending responses are lost.

Optional Feature:
MMIO_ERR_RESP_EN
- Defined: invalid-address reads return data 64'hDEAD_DEAD_DEAD_DEAD with tag 8'd3. Invalid writes also push a response {0, 8'd3}. Valid writes produce no response.
- Undefined: behaviour exactly as above.

Decomposition:
- Package mmio_csr_pkg holds:
  - register offset localparams
  - OP_READ / OP_WRITE
  - RSP_TAG_OK = 8'd2, RSP_TAG_ERR = 8'd3
  - typedef ch_regs_t (struct of the eight 64-bit registers)
  - function decoding address into {ch, reg_idx, valid}
- Sub-module mmio_rsp_fifo: 72-bit synchronous FIFO with count output, parameter DEPTH, plus the registered output stage with a hold input.

Test Plan:
- Write ch1 SRC=0x1000 at 0x48, then read 0x48 -> read_data {0x1000, 0x02} after 2 cycles; ch0 SRC still 0.
- Hold read_data_ready=0 and issue 6 reads (RSP_DEPTH=4) -> payload_ready low after the 4th buffered read beyond the output stage. Then release -> all responses return in order with no loss.
- Assert dma_output_active for 10 cycles with 2 reads pending -> read_data_valid stays 0. Deassert -> first response valid the next cycle.
- Pulse dma_status_valid[0] with dma_status[0]=1 and write 0x1 to STATUS 0x20 in the same cycle -> STATUS reads 0x1. Write 0x1 alone next -> STATUS reads 0x0.
- Write CMD ch0=0x3 with clear_dma_start[0] in the same cycle -> dma_start[0]=1, dma_direction[0]=1. A later clear alone -> CMD 0.
- Read 0x88 with NUM_CH=2 -> {0, 0x02}; with MMIO_ERR_RESP_EN -> {0xDEADDEADDEADDEAD, 0x03}.
